ulpi_reg_arbiter: RTL and testbench
===================================

// Module: ulpi_reg_arbiter
// PURPOSE
//  Shares the single ULPI PHY register-access port (REG_EN/RW/ADDR/DATA, DONE/FAIL) among NUM_REQ clients.
//  Clients are the PHY init sequencer, scratch-register self-test and the host debug path.
//  Round-robin grant, one transaction in flight, per-transaction timeout, per-client DONE/FAIL return.
//  Sits between the clients and ULPI_0 in top, all in the CLK_60M domain.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  TIMEOUT_CYC  255  max CLK_60M cycles in WAIT before forced FAIL (1..65535)
// PORTS
//  CLK_60M      in   1          60 MHz PHY clock; all logic on posedge
//  NRST_A_USB   in   1          reset, asynchronous, active-low
//  REQ_VALID    in   NUM_REQ    client i requests; holds RW/ADDR/WDATA stable until REQ_GRANT[i]
//  REQ_RW       in   NUM_REQ    1=write, 0=read, per client
//  REQ_ADDR     in   6*NUM_REQ  ULPI register address, client i at [6i+5:6i]
//  REQ_WDATA    in   8*NUM_REQ  write data, client i at [8i+7:8i]
//  REQ_GRANT    out  NUM_REQ    one-cycle pulse: request of client i accepted
//  RSP_DONE     out  NUM_REQ    one-cycle pulse: client i transaction completed OK
//  RSP_FAIL     out  NUM_REQ    one-cycle pulse: client i transaction failed/timed out/aborted
//  RSP_RDATA    out  8          read data, valid in the RSP_DONE cycle of a read
//  BUSY         out  1          transaction in flight (state != IDLE)
//  REG_EN       out  1          to ULPI: one-cycle start strobe
//  REG_RW       out  1          to ULPI: 1=write
//  REG_ADDR     out  6          to ULPI: register address
//  REG_DATA_I   out  8          to ULPI: write data
//  REG_DATA_O   in   8          from ULPI: read data, valid with REG_DONE
//  REG_DONE     in   1          from ULPI: transaction done
//  REG_FAIL     in   1          from ULPI: transaction failed
//  READY        in   1          from ULPI: PHY initialised, link usable
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, rr pointer 0, owner 0, timer 0.
//  - States: IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: if READY and |REQ_VALID, pick winner by round-robin from pointer; latch RW/ADDR/WDATA and owner.
//    Next cycle (ISSUE): REG_EN=1 and REQ_GRANT[owner]=1 for exactly that one cycle; REG_RW/ADDR/DATA_I hold latched values ISSUE..WAIT end.
//  - Latency: VALID sampled at edge t -> GRANT/REG_EN high in cycle t+1 -> WAIT from t+2.
//  - Round-robin: pointer = (owner+1) mod NUM_REQ, updated at grant; search pointer, pointer+1, ... wrapping.
//  - WAIT: timer increments each cycle from 0.
//      REG_DONE -> RSP_DONE[owner] pulse; on read RSP_RDATA <= REG_DATA_O; -> IDLE.
//      REG_FAIL (no DONE) -> RSP_FAIL[owner] pulse -> IDLE.
//      DONE and FAIL same cycle: DONE wins.
//      timer == TIMEOUT_CYC-1 with no DONE/FAIL -> RSP_FAIL[owner] -> IDLE.
//  - RSP_RDATA holds its last value otherwise; it is not updated on write or fail.
//  - READY low in ISSUE/WAIT: abort, RSP_FAIL[owner] pulse, -> IDLE; no new grants while READY low.
//    A same-cycle REG_DONE still wins.
//  - VALID still high after its GRANT counts as a new request at the next IDLE, subject to the round robin.
//  - VALID dropped before GRANT: request is withdrawn, nothing issued.
//  - No back-to-back: at least one IDLE cycle between transactions (RSP and next arbitration not overlapped).
//  - Async reset mid-transaction: all outputs to 0 immediately; no RSP pulse is generated.
//  - Timer width: clog2(TIMEOUT_CYC+1) bits, saturating, never wraps.
// STRUCTURE
//  - Shared package ulpi_pkg: ULPI register address constants (FUNC_CTRL 0x04, OTG_CTRL 0x0A, SCRATCH 0x16),
//    arbiter state encoding (IDLE/ISSUE/WAIT), ULPI_ADDR_W=6, ULPI_DATA_W=8.
//  - One sub-module rr_arbiter (NUM_REQ): combinational one-hot winner from REQ_VALID and pointer.
//  - The FSM, latches and timer stay in ulpi_reg_arbiter.
// TESTING
//  - Reset then READY=1, client0 write 0x16<-0xA5, model DONE after 5 cyc -> GRANT[0] and REG_EN one cycle, same cycle,
//    ADDR=0x16 DATA_I=0xA5 RW=1, RSP_DONE[0] 1 cycle after DONE.
//  - All 4 VALID held high, always DONE -> grant order 0,1,2,3,0; never 2 grants in flight; BUSY low between.
//  - Client2 read 0x0A, model returns 0x3C with DONE -> RSP_DONE[2] with RSP_RDATA=0x3C; a later write leaves it at 0x3C.
//  - Model never responds, TIMEOUT_CYC=16 -> RSP_FAIL[owner] after 16 WAIT cycles; next request is served normally.
//  - REG_DONE and REG_FAIL same cycle -> RSP_DONE only; READY drops during WAIT -> RSP_FAIL, no GRANT until READY=1.
//  - NRST_A_USB asserted during WAIT -> outputs 0 asynchronously, no RSP pulse; after release, pointer restarts at client 0.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: register addresses, bus widths and the
// register-access arbiter state encoding.
package ulpi_pkg;

   localparam int unsigned ULPI_ADDR_W = 6;
   localparam int unsigned ULPI_DATA_W = 8;

   // ULPI PHY register addresses used by the clients
   localparam logic [ULPI_ADDR_W-1:0] ULPI_FUNC_CTRL = 6'h04;
   localparam logic [ULPI_ADDR_W-1:0] ULPI_OTG_CTRL  = 6'h0A;
   localparam logic [ULPI_ADDR_W-1:0] ULPI_SCRATCH   = 6'h16;

   // Arbiter FSM encoding
   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot winner among the asserted
// requests, searching from ptr upward and wrapping at NUM_REQ.
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    highest-priority requester index
//   gnt_c  out  NUM_REQ  one-hot winner (all zero when no request)
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_c
);

   localparam int unsigned SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] idx;
   logic             found;

   // First requester at or after ptr, modulo NUM_REQ
   always_comb begin
      gnt_c = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr} + SUM_W'(i);
         if (idx >= SUM_W'(NUM_REQ)) idx = idx - SUM_W'(NUM_REQ);
         if (!found && req[idx[PTR_W-1:0]]) begin
            gnt_c[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Shares the ULPI PHY register-access port among NUM_REQ clients:
// round-robin grant, one transaction in flight, per-transaction timeout,
// per-client DONE/FAIL pulses.
//   CLK_60M, NRST_A_USB              clock, async active-low reset
//   REQ_VALID/RW/ADDR/WDATA          client requests (packed per client)
//   REQ_GRANT, RSP_DONE, RSP_FAIL    per-client one-cycle pulses
//   RSP_RDATA                        last successful read data
//   BUSY                             transaction in flight
//   REG_EN/RW/ADDR/DATA_I            to ULPI register port
//   REG_DATA_O/DONE/FAIL, READY      from ULPI
module ulpi_reg_arbiter
   import ulpi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                           CLK_60M,
   input  logic                           NRST_A_USB,
   input  logic [NUM_REQ-1:0]             REQ_VALID,
   input  logic [NUM_REQ-1:0]             REQ_RW,
   input  logic [ULPI_ADDR_W*NUM_REQ-1:0] REQ_ADDR,
   input  logic [ULPI_DATA_W*NUM_REQ-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]             REQ_GRANT,
   output logic [NUM_REQ-1:0]             RSP_DONE,
   output logic [NUM_REQ-1:0]             RSP_FAIL,
   output logic [ULPI_DATA_W-1:0]         RSP_RDATA,
   output logic                           BUSY,
   output logic                           REG_EN,
   output logic                           REG_RW,
   output logic [ULPI_ADDR_W-1:0]         REG_ADDR,
   output logic [ULPI_DATA_W-1:0]         REG_DATA_I,
   input  logic [ULPI_DATA_W-1:0]         REG_DATA_O,
   input  logic                           REG_DONE,
   input  logic                           REG_FAIL,
   input  logic                           READY
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

   logic [ST_W-1:0]        state, state_nxt;
   logic [PTR_W-1:0]       owner, owner_nxt;
   logic [PTR_W-1:0]       ptr, ptr_nxt;
   logic [TMR_W-1:0]       timer, timer_nxt;
   logic [NUM_REQ-1:0]     grant_nxt, done_nxt, fail_nxt;
   logic [ULPI_DATA_W-1:0] rdata_nxt, data_nxt;
   logic [ULPI_ADDR_W-1:0] addr_nxt;
   logic                   busy_nxt, en_nxt, rw_nxt;

   logic [NUM_REQ-1:0]     win_gnt;
   logic [PTR_W-1:0]       win_idx;
   logic                   win_rw;
   logic [ULPI_ADDR_W-1:0] win_addr;
   logic [ULPI_DATA_W-1:0] win_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req   (REQ_VALID),
      .ptr   (ptr),
      .gnt_c (win_gnt)
   );

   // Winner index and its request fields
   always_comb begin
      win_idx  = '0;
      win_rw   = 1'b0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_gnt[i]) begin
            win_idx  = PTR_W'(i);
            win_rw   = REQ_RW[i];
            win_addr = REQ_ADDR[i*ULPI_ADDR_W +: ULPI_ADDR_W];
            win_data = REQ_WDATA[i*ULPI_DATA_W +: ULPI_DATA_W];
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
      if (!NRST_A_USB) begin
         state      <= ST_IDLE;
         owner      <= '0;
         ptr        <= '0;
         timer      <= '0;
         REQ_GRANT  <= '0;
         RSP_DONE   <= '0;
         RSP_FAIL   <= '0;
         RSP_RDATA  <= '0;
         BUSY       <= 1'b0;
         REG_EN     <= 1'b0;
         REG_RW     <= 1'b0;
         REG_ADDR   <= '0;
         REG_DATA_I <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         ptr        <= ptr_nxt;
         timer      <= timer_nxt;
         REQ_GRANT  <= grant_nxt;
         RSP_DONE   <= done_nxt;
         RSP_FAIL   <= fail_nxt;
         RSP_RDATA  <= rdata_nxt;
         BUSY       <= busy_nxt;
         REG_EN     <= en_nxt;
         REG_RW     <= rw_nxt;
         REG_ADDR   <= addr_nxt;
         REG_DATA_I <= data_nxt;
      end
   end

   // Next state and next output values
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      timer_nxt = timer;
      grant_nxt = '0;
      done_nxt  = '0;
      fail_nxt  = '0;
      rdata_nxt = RSP_RDATA;
      en_nxt    = 1'b0;
      rw_nxt    = REG_RW;
      addr_nxt  = REG_ADDR;
      data_nxt  = REG_DATA_I;

      case (state)
         ST_IDLE: begin
            if (READY && (|REQ_VALID)) begin
               state_nxt = ST_ISSUE;
               owner_nxt = win_idx;
               ptr_nxt   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(win_idx + 1'b1);
               timer_nxt = '0;
               grant_nxt = win_gnt;
               en_nxt    = 1'b1;
               rw_nxt    = win_rw;
               addr_nxt  = win_addr;
               data_nxt  = win_data;
            end
         end

         ST_ISSUE: begin
            if (!READY) begin
               fail_nxt[owner] = 1'b1;
               state_nxt       = ST_IDLE;
            end else begin
               state_nxt = ST_WAIT;
               timer_nxt = '0;
            end
         end

         ST_WAIT: begin
            // DONE takes priority over FAIL, link loss and timeout
            if (REG_DONE) begin
               done_nxt[owner] = 1'b1;
               if (!REG_RW) rdata_nxt = REG_DATA_O;
               state_nxt = ST_IDLE;
            end else if (REG_FAIL || !READY || (timer == TMR_W'(TIMEOUT_CYC - 1))) begin
               fail_nxt[owner] = 1'b1;
               state_nxt       = ST_IDLE;
            end else if (timer != {TMR_W{1'b1}}) begin
               timer_nxt = timer + 1'b1;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed bench for ulpi_reg_arbiter: single write, round-robin order,
// read data capture/hold, timeout, DONE/FAIL priority, READY abort and
// asynchronous reset mid-transaction.
module tb_ulpi_reg_arbiter;
   import ulpi_pkg::*;

   localparam int unsigned N = 4;

   logic         CLK_60M = 1'b0;
   logic         NRST_A_USB;
   logic [N-1:0] REQ_VALID;
   logic [N-1:0] REQ_RW;
   logic [6*N-1:0] REQ_ADDR;
   logic [8*N-1:0] REQ_WDATA;
   logic [N-1:0] REQ_GRANT, RSP_DONE, RSP_FAIL;
   logic [7:0]   RSP_RDATA;
   logic         BUSY, REG_EN, REG_RW;
   logic [5:0]   REG_ADDR;
   logic [7:0]   REG_DATA_I, REG_DATA_O;
   logic         REG_DONE, REG_FAIL, READY;

   int n_chk  = 0;
   int n_pass = 0;

   ulpi_reg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
      .CLK_60M    (CLK_60M),
      .NRST_A_USB (NRST_A_USB),
      .REQ_VALID  (REQ_VALID),
      .REQ_RW     (REQ_RW),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_WDATA  (REQ_WDATA),
      .REQ_GRANT  (REQ_GRANT),
      .RSP_DONE   (RSP_DONE),
      .RSP_FAIL   (RSP_FAIL),
      .RSP_RDATA  (RSP_RDATA),
      .BUSY       (BUSY),
      .REG_EN     (REG_EN),
      .REG_RW     (REG_RW),
      .REG_ADDR   (REG_ADDR),
      .REG_DATA_I (REG_DATA_I),
      .REG_DATA_O (REG_DATA_O),
      .REG_DONE   (REG_DONE),
      .REG_FAIL   (REG_FAIL),
      .READY      (READY)
   );

   always #8 CLK_60M = ~CLK_60M;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK_60M);
      #1;
   endtask

   task automatic set_client(input int i, input logic rw, input logic [5:0] addr, input logic [7:0] data);
      REQ_RW[i]          = rw;
      REQ_ADDR[i*6 +: 6] = addr;
      REQ_WDATA[i*8 +: 8] = data;
   endtask

   task automatic apply_reset();
      NRST_A_USB = 1'b0;
      tick();
      tick();
      NRST_A_USB = 1'b1;
   endtask

   // Wait (bounded) for the issue cycle; report granted client and cycles waited
   task automatic wait_grant(output int who, output int n);
      who = -1;
      n   = 0;
      while (!REG_EN && n < 20) begin
         tick();
         n++;
      end
      for (int i = 0; i < N; i++) if (REQ_GRANT[i]) who = i;
      chk("grant_seen", 64'(REG_EN), 64'(1));
      chk("grant_onehot", 64'($countones(REQ_GRANT)), 64'(1));
   endtask

   // PHY answers lat cycles after the issue cycle; ends in the response cycle
   task automatic respond(input int lat, input logic d, input logic f, input logic [7:0] rd);
      logic extra;
      extra = 1'b0;
      for (int k = 0; k < lat; k++) begin
         tick();
         if (REQ_GRANT != '0) extra = 1'b1;
      end
      REG_DONE   = d;
      REG_FAIL   = f;
      REG_DATA_O = rd;
      tick();
      REG_DONE   = 1'b0;
      REG_FAIL   = 1'b0;
      REG_DATA_O = 8'h00;
      chk("no_grant_in_flight", 64'(extra), 64'(0));
   endtask

   initial begin
      int who, n;
      logic seen;

      NRST_A_USB = 1'b0;
      REQ_VALID  = '0;
      REQ_RW     = '0;
      REQ_ADDR   = '0;
      REQ_WDATA  = '0;
      REG_DATA_O = '0;
      REG_DONE   = 1'b0;
      REG_FAIL   = 1'b0;
      READY      = 1'b0;
      tick();
      tick();
      chk("reset_outputs",
          64'({REQ_GRANT, RSP_DONE, RSP_FAIL, RSP_RDATA, BUSY, REG_EN, REG_RW, REG_ADDR, REG_DATA_I}),
          64'(0));
      NRST_A_USB = 1'b1;
      READY      = 1'b1;

      // Single write from client 0
      set_client(0, 1'b1, ULPI_SCRATCH, 8'hA5);
      REQ_VALID = 4'b0001;
      wait_grant(who, n);
      chk("w0_latency", 64'(n), 64'(1));
      chk("w0_grant", 64'(REQ_GRANT), 64'(4'b0001));
      chk("w0_fields", 64'({REG_RW, REG_ADDR, REG_DATA_I}), 64'({1'b1, 6'h16, 8'hA5}));
      chk("w0_busy", 64'(BUSY), 64'(1));
      REQ_VALID = '0;
      tick();
      chk("w0_en_pulse", 64'({REG_EN, REQ_GRANT}), 64'(0));
      chk("w0_fields_hold", 64'({REG_RW, REG_ADDR, REG_DATA_I}), 64'({1'b1, 6'h16, 8'hA5}));
      chk("w0_no_early_rsp", 64'({RSP_DONE, RSP_FAIL}), 64'(0));
      respond(4, 1'b1, 1'b0, 8'h00);
      chk("w0_done", 64'(RSP_DONE), 64'(4'b0001));
      chk("w0_no_fail", 64'(RSP_FAIL), 64'(0));
      chk("w0_idle", 64'(BUSY), 64'(0));
      tick();
      chk("w0_done_pulse", 64'(RSP_DONE), 64'(0));

      // Round-robin with all clients requesting
      apply_reset();
      for (int i = 0; i < N; i++) set_client(i, 1'b1, 6'(i), 8'(8'h10 + i));
      REQ_VALID = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(who, n);
         chk("rr_order", 64'(who), 64'(k % 4));
         chk("rr_gap", 64'(n), 64'(1));
         chk("rr_addr", 64'(REG_ADDR), 64'(k % 4));
         respond(2, 1'b1, 1'b0, 8'h00);
         chk("rr_done", 64'(RSP_DONE), 64'(1) << (k % 4));
         chk("rr_busy_low", 64'(BUSY), 64'(0));
      end
      REQ_VALID = '0;
      tick();

      // Read from client 2 captures data; later write and failed read keep it
      set_client(2, 1'b0, ULPI_OTG_CTRL, 8'h00);
      REQ_VALID = 4'b0100;
      wait_grant(who, n);
      chk("rd_owner", 64'(who), 64'(2));
      chk("rd_fields", 64'({REG_RW, REG_ADDR}), 64'({1'b0, 6'h0A}));
      REQ_VALID = '0;
      respond(3, 1'b1, 1'b0, 8'h3C);
      chk("rd_done", 64'(RSP_DONE), 64'(4'b0100));
      chk("rd_data", 64'(RSP_RDATA), 64'(8'h3C));
      set_client(1, 1'b1, ULPI_FUNC_CTRL, 8'h55);
      REQ_VALID = 4'b0010;
      wait_grant(who, n);
      chk("wr_fields", 64'({REG_RW, REG_ADDR, REG_DATA_I}), 64'({1'b1, 6'h04, 8'h55}));
      REQ_VALID = '0;
      respond(2, 1'b1, 1'b0, 8'h99);
      chk("wr_done", 64'(RSP_DONE), 64'(4'b0010));
      chk("wr_keeps_rdata", 64'(RSP_RDATA), 64'(8'h3C));
      set_client(2, 1'b0, ULPI_SCRATCH, 8'h00);
      REQ_VALID = 4'b0100;
      wait_grant(who, n);
      REQ_VALID = '0;
      respond(2, 1'b0, 1'b1, 8'h77);
      chk("rdfail_fail", 64'({RSP_DONE, RSP_FAIL}), 64'({4'b0000, 4'b0100}));
      chk("rdfail_keeps_rdata", 64'(RSP_RDATA), 64'(8'h3C));

      // Timeout with silent PHY, then normal service
      set_client(3, 1'b1, ULPI_SCRATCH, 8'h5A);
      REQ_VALID = 4'b1000;
      wait_grant(who, n);
      REQ_VALID = '0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (RSP_FAIL != '0) seen = 1'b1;
      end
      chk("to_cycles", 64'(n), 64'(17));
      chk("to_fail", 64'({RSP_DONE, RSP_FAIL}), 64'({4'b0000, 4'b1000}));
      set_client(0, 1'b0, ULPI_SCRATCH, 8'h00);
      REQ_VALID = 4'b0001;
      wait_grant(who, n);
      chk("post_to_owner", 64'(who), 64'(0));
      REQ_VALID = '0;
      respond(1, 1'b1, 1'b0, 8'hC3);
      chk("post_to_done", 64'({RSP_DONE, RSP_FAIL, RSP_RDATA}), 64'({4'b0001, 4'b0000, 8'hC3}));

      // DONE and FAIL together: DONE wins
      set_client(1, 1'b0, ULPI_SCRATCH, 8'h00);
      REQ_VALID = 4'b0010;
      wait_grant(who, n);
      REQ_VALID = '0;
      respond(2, 1'b1, 1'b1, 8'h11);
      chk("df_done_only", 64'({RSP_DONE, RSP_FAIL, RSP_RDATA}), 64'({4'b0010, 4'b0000, 8'h11}));

      // READY drop in WAIT aborts; no grant while READY low
      set_client(2, 1'b1, ULPI_SCRATCH, 8'h22);
      REQ_VALID = 4'b0100;
      wait_grant(who, n);
      tick();
      READY = 1'b0;
      tick();
      chk("rdy_abort", 64'({RSP_DONE, RSP_FAIL}), 64'({4'b0000, 4'b0100}));
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (REQ_GRANT != '0 || BUSY) seen = 1'b1;
      end
      chk("rdy_no_grant", 64'(seen), 64'(0));
      READY = 1'b1;
      wait_grant(who, n);
      chk("rdy_regrant", 64'({who, n}), 64'({32'd2, 32'd1}));
      REQ_VALID = '0;
      // READY low with same-cycle DONE: DONE wins
      tick();
      READY    = 1'b0;
      REG_DONE = 1'b1;
      tick();
      READY    = 1'b1;
      REG_DONE = 1'b0;
      chk("rdy_done_wins", 64'({RSP_DONE, RSP_FAIL}), 64'({4'b0100, 4'b0000}));

      // Asynchronous reset during WAIT
      set_client(3, 1'b1, ULPI_OTG_CTRL, 8'h33);
      REQ_VALID = 4'b1000;
      wait_grant(who, n);
      tick();
      #3;
      NRST_A_USB = 1'b0;
      #1;
      chk("arst_outputs",
          64'({REQ_GRANT, RSP_DONE, RSP_FAIL, RSP_RDATA, BUSY, REG_EN, REG_RW, REG_ADDR, REG_DATA_I}),
          64'(0));
      REG_DONE = 1'b1;
      tick();
      chk("arst_no_rsp", 64'({RSP_DONE, RSP_FAIL, BUSY}), 64'(0));
      REG_DONE   = 1'b0;
      REQ_VALID  = 4'b1111;
      NRST_A_USB = 1'b1;
      chk("arst_release_quiet", 64'({RSP_DONE, RSP_FAIL}), 64'(0));
      wait_grant(who, n);
      chk("arst_ptr_restart", 64'(who), 64'(0));
      REQ_VALID = '0;
      respond(1, 1'b1, 1'b0, 8'h00);
      chk("arst_after_done", 64'(RSP_DONE), 64'(4'b0001));

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
